// File: rtl/seq_chk_pkg.sv
// Shared types for the sequence-operation checker family (AND now, OR/THROUGHOUT later).
package seq_chk_pkg;

  typedef enum logic [1:0] {MODE_SEQ, MODE_CYC, MODE_ALL, MODE_RSVD} mode_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

endpackage

// File: rtl/seq_win_cnt.sv
// Window sample counter; last_o flags that the current sample is WIN-1.
module seq_win_cnt #(
  parameter int unsigned WIN = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int unsigned CntW = $clog2(WIN + 1);

  if (WIN == 1) begin : g_no_cnt
    // Every sample is the last one, so there is nothing to count.
    logic unused_in;
    assign unused_in = ^{clk_i, rst_ni, clear_i, inc_i};
    assign last_o    = 1'b1;
  end else begin : g_cnt
    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (inc_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Counter sits at 0 while idle, so this also covers sample 0.
    assign last_o = (cnt_q == CntW'(WIN - 1));
  end

endmodule

// File: rtl/seq_and_chk.sv
// Sequence-AND checker: opens a WIN-cycle window on en and pulses match/fail once decided.
module seq_and_chk
  import seq_chk_pkg::*;
#(
  parameter int unsigned N_SIG = 2,
  parameter int unsigned WIN   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic [N_SIG-1:0] mask_i,
  input  logic [N_SIG-1:0] sig_i,
  output logic             match_o,
  output logic             fail_o,
  output logic             busy_o,
  output logic             drop_o,
  output logic [N_SIG-1:0] seen_o
);

  state_e           state_d, state_q;
  mode_e            mode_d, mode_q, eff_mode;
  logic [N_SIG-1:0] mask_d, mask_q, eff_mask;
  logic [N_SIG-1:0] seen_d, seen_q, seen_nxt;
  logic             match_d, match_q, fail_d, fail_q, drop_d, drop_q;
  logic             idle, start, active, hit, all_seen, ok, bad;
  logic             cnt_clr, cnt_inc, last;

  seq_win_cnt #(
    .WIN(WIN)
  ) u_win_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (last)
  );

  assign idle   = (state_q == S_IDLE);
  assign start  = idle && en_i;
  assign active = start || (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    seen_d   = seen_q;
    match_d  = 1'b0;
    fail_d   = 1'b0;
    drop_d   = (state_q == S_RUN) && en_i;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    ok       = 1'b0;
    bad      = 1'b0;

    // Sample 0 uses the live mode/mask; later samples use the latched copies.
    eff_mode = idle ? mode_i : mode_q;
    eff_mask = idle ? mask_i : mask_q;
    seen_nxt = (idle ? '0 : seen_q) | (sig_i & eff_mask);
    hit      = &(sig_i | ~eff_mask);
    all_seen = &(seen_nxt | ~eff_mask);

    if (eff_mask == '0) begin
      ok = 1'b1;
    end else begin
      unique case (eff_mode)
        MODE_SEQ: begin
          ok  = all_seen;
          bad = !all_seen && last;
        end
        MODE_ALL: begin
          bad = !hit;
          ok  = hit && last;
        end
        MODE_CYC, MODE_RSVD: begin
          ok  = hit;
          bad = !hit && last;
        end
        default: ;
      endcase
    end

    if (active) begin
      seen_d  = seen_nxt;
      match_d = ok;
      fail_d  = bad;
    end

    if (start) begin
      mode_d = mode_i;
      mask_d = mask_i;
      if (!(ok || bad)) begin
        state_d = S_RUN;
        cnt_inc = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      if (ok || bad) begin
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SEQ;
      mask_q  <= '0;
      seen_q  <= '0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      drop_q  <= drop_d;
    end
  end

  assign match_o = match_q;
  assign fail_o  = fail_q;
  assign busy_o  = (state_q == S_RUN);
  assign drop_o  = drop_q;
  assign seen_o  = seen_q;

endmodule

// File: tb/tb_seq_and_chk.sv
// Directed + random bench for seq_and_chk against a window-list reference model.
module tb_seq_and_chk;
  import seq_chk_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  mode_e        mode = MODE_SEQ;
  logic [N-1:0] mask = '0;
  logic [N-1:0] sig = '0;
  logic         match, fail, busy, drop;
  logic [N-1:0] seen;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the samples of the open window, re-evaluated as a whole each cycle.
  logic [N-1:0] m_samp[$];
  bit           m_busy;
  logic [1:0]   m_mode;
  logic [N-1:0] m_mask;
  bit           e_match, e_fail, e_drop;
  logic [N-1:0] e_seen;

  seq_and_chk #(
    .N_SIG(N),
    .WIN  (W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .mode_i (mode),
    .mask_i (mask),
    .sig_i  (sig),
    .match_o(match),
    .fail_o (fail),
    .busy_o (busy),
    .drop_o (drop),
    .seen_o (seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_samp.delete();
    m_busy  = 0;
    e_match = 0;
    e_fail  = 0;
    e_drop  = 0;
    e_seen  = '0;
  endtask

  task automatic model_step(input logic e, input logic [1:0] md, input logic [N-1:0] mk,
                            input logic [N-1:0] s);
    bit           started, any_hit, any_miss, lst, ok, bad;
    logic [N-1:0] sn;
    e_drop  = m_busy && e;
    e_match = 0;
    e_fail  = 0;
    started = !m_busy && e;
    if (started) begin
      m_mode = md;
      m_mask = mk;
      m_samp.delete();
    end
    if (m_busy || started) begin
      m_samp.push_back(s);
      sn       = '0;
      any_hit  = 0;
      any_miss = 0;
      foreach (m_samp[i]) begin
        sn |= m_samp[i] & m_mask;
        if ((m_samp[i] | ~m_mask) == '1) any_hit = 1;
        else any_miss = 1;
      end
      lst = (m_samp.size() == W);
      ok  = 0;
      bad = 0;
      if (m_mask == '0) ok = 1;
      else if (m_mode == 2'd0) begin
        if ((sn | ~m_mask) == '1) ok = 1;
        else if (lst) bad = 1;
      end else if (m_mode == 2'd2) begin
        if (any_miss) bad = 1;
        else if (lst) ok = 1;
      end else begin
        if (any_hit) ok = 1;
        else if (lst) bad = 1;
      end
      e_match = ok;
      e_fail  = bad;
      e_seen  = sn;
      m_busy  = !(ok || bad);
    end
  endtask

  task automatic check_all();
    chk("match", 32'(match), 32'(e_match));
    chk("fail", 32'(fail), 32'(e_fail));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("drop", 32'(drop), 32'(e_drop));
    chk("seen", 32'(seen), 32'(e_seen));
  endtask

  task automatic cyc(input logic e, input logic [1:0] md, input logic [N-1:0] mk,
                     input logic [N-1:0] s);
    en   = e;
    mode = mode_e'(md);
    mask = mk;
    sig  = s;
    @(posedge clk);
    model_step(e, md, mk, s);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 2'b11, 2'b00);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // MODE_CYC: hit only at sample 2 -> match at t3.
    cyc(1, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b11);
    chk("cyc_match_t3", 32'(match), 32'd1);
    idle_cycles(2);

    // MODE_SEQ: bits high at different samples -> match at t4.
    cyc(1, 2'd0, 2'b11, 2'b00);
    cyc(0, 2'd0, 2'b11, 2'b01);
    cyc(0, 2'd0, 2'b11, 2'b00);
    cyc(0, 2'd0, 2'b11, 2'b10);
    chk("seq_match_t4", 32'(match), 32'd1);
    chk("seq_seen", 32'(seen), 32'd3);
    idle_cycles(1);

    // Same stimulus in MODE_CYC -> fail at t5.
    cyc(1, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b01);
    cyc(0, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b10);
    cyc(0, 2'd1, 2'b11, 2'b00);
    chk("cyc_fail_t5", 32'(fail), 32'd1);
    idle_cycles(1);

    // MODE_ALL: miss at sample 2 -> fail at t3; then all hits -> match at t5.
    cyc(1, 2'd2, 2'b11, 2'b11);
    cyc(0, 2'd2, 2'b11, 2'b11);
    cyc(0, 2'd2, 2'b11, 2'b01);
    idle_cycles(1);
    for (int i = 0; i < W; i++) cyc(i == 0, 2'd2, 2'b11, 2'b11);
    chk("all_match_t5", 32'(match), 32'd1);
    idle_cycles(1);

    // en during RUN -> drop, window unchanged.
    cyc(1, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b00);
    cyc(1, 2'd1, 2'b11, 2'b00);
    chk("drop_t3", 32'(drop), 32'd1);
    cyc(0, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b00);
    idle_cycles(3);

    // Asynchronous reset mid-window.
    cyc(1, 2'd1, 2'b11, 2'b00);
    cyc(0, 2'd1, 2'b11, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(6);

    // Vacuous mask: match at t1, en at t1 accepted without drop.
    cyc(1, 2'd2, 2'b00, 2'b00);
    chk("vac_match_t1", 32'(match), 32'd1);
    cyc(1, 2'd1, 2'b11, 2'b11);
    chk("vac_no_drop", 32'(drop), 32'd0);
    idle_cycles(1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] s;
      s = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
